// File: rtl/ag_channel_ctrl_core.sv
// Multi-channel bang-bang actuator controller: hysteresis thresholds, dwell timers,
// max-on watchdog with latched fault, and a free-running status heartbeat.
module ag_channel_ctrl_core #(
    parameter int N_CH    = 5,
    parameter int SW      = 2,
    parameter int MIN_ON  = 16,
    parameter int MIN_OFF = 16,
    parameter int MAX_ON  = 1_000_000,
    parameter int HB_HALF = 12_500_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic [N_CH*SW-1:0]   sensor_bus,
    input  logic [N_CH*SW-1:0]   on_thr_bus,
    input  logic [N_CH*SW-1:0]   off_thr_bus,
    input  logic [N_CH-1:0]      mode,
    input  logic [N_CH-1:0]      ch_en,
    input  logic                 cmd_override,
    input  logic                 fault_clr,
    output logic [N_CH-1:0]      ctrl,
    output logic [N_CH-1:0]      fault,
    output logic                 fault_any,
    output logic                 heartbeat
);

    localparam int CNT_MAX_A = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
    localparam int CNT_MAX   = (MAX_ON > CNT_MAX_A) ? MAX_ON : CNT_MAX_A;
    localparam int CW        = $clog2(CNT_MAX + 1);
    localparam int HW        = (HB_HALF > 1) ? $clog2(HB_HALF) : 1;

    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
    localparam logic [CW-1:0] MIN_ON_C  = CW'(MIN_ON);
    localparam logic [CW-1:0] MIN_OFF_C = CW'(MIN_OFF);
    localparam logic [CW-1:0] MAX_ON_C  = CW'(MAX_ON);
    localparam logic [HW-1:0] HB_LAST   = HW'(HB_HALF - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_FAULT = 2'd2
    } ch_state_t;

    ch_state_t       state_q [N_CH];
    ch_state_t       state_d [N_CH];
    logic [CW-1:0]   cnt_q   [N_CH];
    logic [CW-1:0]   cnt_d   [N_CH];
    logic [N_CH-1:0] request_on;
    logic [N_CH-1:0] release_ok;
    logic            ovr_q;
    logic [HW-1:0]   hb_cnt;
    logic            hb_q;

    // Direction-dependent comparisons: mode 1 inverts the sense of both thresholds.
    always_comb begin
        request_on = '0;
        release_ok = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (mode[i]) begin
                request_on[i] = sensor_bus[i*SW +: SW] >  on_thr_bus[i*SW +: SW];
                release_ok[i] = sensor_bus[i*SW +: SW] <= off_thr_bus[i*SW +: SW];
            end else begin
                request_on[i] = sensor_bus[i*SW +: SW] <  on_thr_bus[i*SW +: SW];
                release_ok[i] = sensor_bus[i*SW +: SW] >= off_thr_bus[i*SW +: SW];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                ST_FAULT: begin
                    if (fault_clr) state_d[i] = ST_OFF;
                end
                ST_ON: begin
                    if (ovr_q || !ch_en[i]) begin
                        state_d[i] = ST_OFF;
                    end else if (release_ok[i] && cnt_q[i] >= MIN_ON_C) begin
                        state_d[i] = ST_OFF;
                    end else if ((MAX_ON != 0) && cnt_q[i] >= MAX_ON_C) begin
                        state_d[i] = ST_FAULT;
                    end
                end
                default: begin
                    if (!ovr_q && ch_en[i] && request_on[i] && cnt_q[i] >= MIN_OFF_C) begin
                        state_d[i] = ST_ON;
                    end
                end
            endcase
            // Forced OFF from OFF is not a state change, so the dwell keeps counting.
            if (state_d[i] != state_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_SAT) begin
                cnt_d[i] = cnt_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= CNT_SAT;
            end
            ovr_q  <= 1'b0;
            hb_cnt <= '0;
            hb_q   <= 1'b0;
        end else if (ena) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ovr_q <= cmd_override;
            if (hb_cnt == HB_LAST) begin
                hb_cnt <= '0;
                hb_q   <= ~hb_q;
            end else begin
                hb_cnt <= hb_cnt + HW'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ctrl[i]  = (state_q[i] == ST_ON);
            fault[i] = (state_q[i] == ST_FAULT);
        end
    end

    assign fault_any = |fault;
    assign heartbeat = hb_q;

endmodule

// File: tb/tb_ag_channel_ctrl_core.sv
// Randomized and directed bench for ag_channel_ctrl_core; expected outputs come from a
// timestamp-based reference model and are checked by a per-cycle monitor.
`timescale 1ns/1ps
module tb_ag_channel_ctrl_core;

    localparam int N_CH    = 2;
    localparam int SW      = 4;
    localparam int MIN_ON  = 3;
    localparam int MIN_OFF = 3;
    localparam int MAX_ON  = 10;
    localparam int HB_HALF = 4;

    localparam int M_OFF   = 0;
    localparam int M_ON    = 1;
    localparam int M_FAULT = 2;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic              ena = 1'b0;
    logic [SW-1:0]     sens    [N_CH];
    logic [SW-1:0]     on_thr  [N_CH];
    logic [SW-1:0]     off_thr [N_CH];
    logic [N_CH-1:0]   mode = '0;
    logic [N_CH-1:0]   ch_en = '1;
    logic              cmd_override = 1'b0;
    logic              fault_clr = 1'b0;

    logic [N_CH*SW-1:0] sensor_bus, on_thr_bus, off_thr_bus;
    logic [N_CH-1:0]    ctrl, fault;
    logic               fault_any, heartbeat;

    assign sensor_bus  = {sens[1], sens[0]};
    assign on_thr_bus  = {on_thr[1], on_thr[0]};
    assign off_thr_bus = {off_thr[1], off_thr[0]};

    ag_channel_ctrl_core #(
        .N_CH(N_CH), .SW(SW), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF),
        .MAX_ON(MAX_ON), .HB_HALF(HB_HALF)
    ) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .sensor_bus(sensor_bus), .on_thr_bus(on_thr_bus), .off_thr_bus(off_thr_bus),
        .mode(mode), .ch_en(ch_en), .cmd_override(cmd_override), .fault_clr(fault_clr),
        .ctrl(ctrl), .fault(fault), .fault_any(fault_any), .heartbeat(heartbeat)
    );

    // scoreboard state
    logic [5:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // reference model: state per channel plus the enabled-edge index at which it was entered
    int  m_edges;
    int  m_state   [N_CH];
    int  m_entered [N_CH];
    bit  m_ovr_prev;

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b (hb,any,fault,ctrl) expected %b at %0t", name, got, exp, $time);
    endtask

    function automatic logic [5:0] model_outputs();
        logic [1:0] c, f;
        logic       hb;
        for (int i = 0; i < N_CH; i++) begin
            c[i] = (m_state[i] == M_ON);
            f[i] = (m_state[i] == M_FAULT);
        end
        hb = ((m_edges / HB_HALF) % 2) == 1;
        return {hb, |f, f, c};
    endfunction

    task automatic model_reset();
        m_edges    = 0;
        m_ovr_prev = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            m_state[i]   = M_OFF;
            m_entered[i] = -100000;
        end
    endtask

    // Predicts the outputs after the coming clock edge from the inputs now applied.
    task automatic model_step();
        int  elapsed, nxt;
        bit  req, rel;
        if (ena) begin
            m_edges++;
            for (int i = 0; i < N_CH; i++) begin
                elapsed = m_edges - m_entered[i] - 1;
                req = mode[i] ? (sens[i] > on_thr[i]) : (sens[i] < on_thr[i]);
                rel = mode[i] ? (sens[i] <= off_thr[i]) : (sens[i] >= off_thr[i]);
                nxt = m_state[i];
                if (m_state[i] == M_FAULT) begin
                    if (fault_clr) nxt = M_OFF;
                end else if (m_ovr_prev || !ch_en[i]) begin
                    nxt = M_OFF;
                end else if (m_state[i] == M_OFF) begin
                    if (req && elapsed >= MIN_OFF) nxt = M_ON;
                end else begin
                    if (rel && elapsed >= MIN_ON) nxt = M_OFF;
                    else if (elapsed >= MAX_ON) nxt = M_FAULT;
                end
                if (nxt != m_state[i]) begin
                    m_state[i]   = nxt;
                    m_entered[i] = m_edges;
                end
            end
            m_ovr_prev = cmd_override;
        end
        exp_q.push_back(model_outputs());
    endtask

    // driver: called at a negedge with inputs already set; returns at the next negedge
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("reset_outputs", {heartbeat, fault_any, fault, ctrl}, 6'b000000);
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_held", {heartbeat, fault_any, fault, ctrl}, 6'b000000);
        rst = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [3:0] s, input logic [3:0] on_t,
                          input logic [3:0] off_t, input logic md);
        sens[i] = s; on_thr[i] = on_t; off_thr[i] = off_t; mode[i] = md;
    endtask

    // monitor: one expected vector per driven cycle
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            check("outputs", {heartbeat, fault_any, fault, ctrl}, exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        set_ch(0, 4'd15, 4'd0, 4'd15, 1'b0);
        set_ch(1, 4'd15, 4'd0, 4'd15, 1'b0);
        @(negedge clk);
        do_reset();
        ena = 1'b1;

        // heartbeat from reset with channels idle
        step(12);

        // hysteresis on ch0
        set_ch(0, 4'd3, 4'd4, 4'd8, 1'b0);
        step(1);
        sens[0] = 4'd6; step(3);
        sens[0] = 4'd9; step(6);

        // dwell-limited cycling on ch1 (mode 1)
        set_ch(1, 4'd12, 4'd10, 4'd5, 1'b1);
        for (int k = 0; k < 30; k++) begin
            sens[1] = (k % 2 == 0) ? 4'd12 : 4'd2;
            step(1);
        end
        sens[1] = 4'd2; step(6);

        // watchdog fault and clear
        set_ch(0, 4'd0, 4'd4, 4'd8, 1'b0);
        step(20);
        fault_clr = 1'b1; step(1);
        fault_clr = 1'b0; step(8);

        // override with both channels ON, then override after a fault
        sens[0] = 4'd9; step(6);
        set_ch(0, 4'd0, 4'd4, 4'd8, 1'b0);
        set_ch(1, 4'd12, 4'd10, 4'd5, 1'b1);
        step(5);
        cmd_override = 1'b1; step(1);
        cmd_override = 1'b0; step(14);
        cmd_override = 1'b1; step(1);
        cmd_override = 1'b0; step(6);
        fault_clr = 1'b1; step(1);
        fault_clr = 1'b0; step(6);

        // reset while ON, then enable hold
        do_reset();
        step(3);
        ena = 1'b0; sens[0] = 4'd15; step(10);
        ena = 1'b1; step(10);

        // randomized phase
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 3) == 0) sens[i] = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 49) == 0) begin
                    on_thr[i]  = 4'($urandom_range(0, 15));
                    off_thr[i] = 4'($urandom_range(0, 15));
                    mode[i]    = 1'($urandom_range(0, 1));
                end
                ch_en[i] = ($urandom_range(0, 19) != 0);
            end
            cmd_override = ($urandom_range(0, 29) == 0);
            fault_clr    = ($urandom_range(0, 24) == 0);
            ena          = ($urandom_range(0, 14) != 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            step(1);
        end

        ena = 1'b1; cmd_override = 1'b0; fault_clr = 1'b0;
        step(2);
        @(posedge clk); #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ag_channel_ctrl_core.md
# ag_channel_ctrl_core

Parametrised successor to the fixed five-actuator control core. It drives N_CH independent bang-bang actuator channels from SW-bit sensor readings. Each channel has programmable on/off thresholds with hysteresis, a direction mode, minimum on/off dwell timers, and a maximum-on watchdog that latches a per-channel fault. It sits between the sensor front-end and the actuator pins in the farming coprocessor, and it also generates the status heartbeat.

## Interface
Parameters:
- N_CH, 5: number of actuator channels.
- SW, 2: sensor and threshold width in bits.
- MIN_ON, 16: minimum ON dwell in cycles (≥1).
- MIN_OFF, 16: minimum OFF dwell in cycles (≥1).
- MAX_ON, 1_000_000: ON-time watchdog in cycles; 0 disables the watchdog.
- HB_HALF, 12_500_000: heartbeat half-period in cycles (≥1).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  global enable; while 0, every register holds its value.
- sensor_bus  in  N_CH*SW  channel i reading is at bits [i*SW +: SW], unsigned.
- on_thr_bus  in  N_CH*SW  per-channel turn-on threshold, same packing as sensor_bus.
- off_thr_bus  in  N_CH*SW  per-channel turn-off threshold, same packing as sensor_bus.
- mode  in  N_CH  per channel: 0 = raise (heater/pump/light), 1 = lower (cooler/dehumidifier).
- ch_en  in  N_CH  per-channel enable; 0 forces the channel OFF.
- cmd_override  in  1  pause request; when active, all actuators go off.
- fault_clr  in  1  synchronous request that clears every faulted channel.
- ctrl  out  N_CH  actuator drive; registered.
- fault  out  N_CH  per-channel latched watchdog fault; registered.
- fault_any  out  1  OR of fault.
- heartbeat  out  1  square wave, toggles every HB_HALF cycles.

## Operation
- Per-channel state machine with states OFF, ON, FAULT. Outputs are decoded from the state register: ctrl[i] = (state==ON), fault[i] = (state==FAULT).
- Each channel has a dwell counter cnt. It is cleared to 0 on every state change, otherwise increments once per enabled cycle, and saturates at max(MIN_ON, MIN_OFF, MAX_ON).
- Request and release conditions:
  - mode 0: request_on = sensor < on_thr; release = sensor ≥ off_thr.
  - mode 1: request_on = sensor > on_thr; release = sensor ≤ off_thr.
- ovr_q is a one-stage register of cmd_override.
- Transitions, evaluated per channel in priority order each enabled cycle:
  - FAULT: fault_clr=1 → OFF with cnt=0. Otherwise stay in FAULT. Override and ch_en do not clear a fault.
  - Any other state with ovr_q=1 or ch_en[i]=0: go to OFF. This bypasses the MIN_ON dwell. cnt is cleared only if the channel was ON.
  - OFF: request_on && cnt ≥ MIN_OFF → ON.
  - ON: release && cnt ≥ MIN_ON → OFF. Otherwise, if MAX_ON≠0 && cnt ≥ MAX_ON → FAULT. Release wins over fault when both hold in the same cycle.
- Only request_on is examined in OFF and only release in ON. Misordered thresholds therefore cause cycling that is rate-limited by the dwell timers. This is not an error condition.
- Heartbeat: hb_cnt counts 0..HB_HALF-1. heartbeat toggles on the wrap.
- The ena=0 hold covers every register, including ovr_q and hb_cnt.

## Timing
- Reset values:
  - All channels OFF, with cnt preset to its saturation value so the first request_on can switch on immediately.
  - ctrl=0, fault=0, fault_any=0, heartbeat=0, hb_cnt=0, ovr_q=0.
- Reset asserted mid-operation returns every register to these values asynchronously. The first update after release happens on the first clk edge with rst=0.
- Sensor/threshold-to-ctrl latency is 1 cycle: inputs sampled at edge k are reflected on ctrl after edge k.
- cmd_override-to-ctrl latency is 2 cycles, because of the ovr_q register.
- After entering OFF at edge k, the earliest ON is edge k+MIN_OFF+1. After entering ON at edge k, the earliest OFF by release is edge k+MIN_ON+1.
- With release held false, ON entered at edge k faults at edge k+MAX_ON+1.
- fault_clr takes effect at the next edge. The channel then obeys MIN_OFF from that edge.
- heartbeat period is 2*HB_HALF enabled cycles.

## Test plan
All scenarios use N_CH=2, SW=4, MIN_ON=3, MIN_OFF=3, MAX_ON=10, HB_HALF=4.
- Hysteresis, ch0 mode0, on_thr=4, off_thr=8: sensor 3 → ctrl[0]=1 one cycle later. Sensor 6 → ctrl stays 1. Sensor 9 → ctrl[0]=0 once ON has lasted ≥4 cycles.
- Dwell: toggle the ch1 (mode1, on_thr=10, off_thr=5) sensor between 12 and 2 every cycle. ctrl[1] never stays high or low for fewer than 4 consecutive cycles.
- Watchdog: hold ch0 sensor=0 with off_thr=8. fault[0]=1 and ctrl[0]=0 exactly 11 cycles after ctrl rose; fault_any=1. Pulse fault_clr → fault[0]=0 next cycle; ctrl[0] returns 4 cycles later.
- Override: with both channels ON, cmd_override=1 for one cycle → ctrl=2'b00 two edges later, even within MIN_ON. A fault latched before the override survives it.
- Reset/enable: assert rst mid-ON → ctrl, fault and heartbeat are all 0 immediately. Hold ena=0 → all outputs frozen, and heartbeat stops toggling.
- Heartbeat: after reset, heartbeat toggles every 4 cycles (period 8).
